// File: rtl/ccip_if_pkg.sv
// ---------------------------------------------------------------------------
// ccip_if_pkg
// Subset of the CCI-P interface types used by the Tx throttle buffer:
// request headers for c0 (memory read) and c1 (memory write), the MMIO read
// response header for c2, and the bundled Tx struct the AFU drives.
// ---------------------------------------------------------------------------
package ccip_if_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [63:0]  t_ccip_mmioData;

    // The encoding is "lines minus one", so a 4-line request carries 2'b11.
    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/ccip_tx_buf_pkg.sv
// ---------------------------------------------------------------------------
// ccip_tx_buf_pkg
// Shared definitions for the Tx throttle buffer: per-channel FIFO entry
// types, default sizing, and the helper that tells how many more beats follow
// a c1 header once it has been popped.
// ---------------------------------------------------------------------------
package ccip_tx_buf_pkg;

    import ccip_if_pkg::*;

    localparam int TXBUF_DEPTH         = 16;
    localparam int TXBUF_ALMFULL_SLACK = 8;

    typedef t_ccip_c0_ReqMemHdr t_c0_entry;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
    } t_c1_entry;

    // Only a start-of-packet beat opens a multi-line burst; the cl_len code
    // (lines minus one) is exactly the number of trailing beats.
    function automatic logic [1:0] extraBeats(input t_ccip_c1_ReqMemHdr hdr);
        return (hdr.sop && (hdr.cl_len != eCL_LEN_1)) ? 2'(hdr.cl_len) : 2'b00;
    endfunction

endpackage

// File: rtl/ccip_tx_chan_fifo.sv
// ---------------------------------------------------------------------------
// ccip_tx_chan_fifo
// Single-channel request FIFO used once per Tx channel. Pushes into a full
// FIFO are dropped and flagged; there is no same-cycle bypass of a full FIFO
// even when a pop happens on that cycle.
//
// Ports:
//   pClk      clock
//   reset     asynchronous active-high reset
//   pushValid request offered by the AFU this cycle
//   pushData  entry to store
//   popReq    consume the head entry (ignored when empty)
//   popData   head entry, valid whenever empty is low
//   empty     no entries stored
//   almFull   registered: next occupancy at or above DEPTH - ALMFULL_SLACK;
//             held high while reset is asserted
//   ovfDrop   pulse: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ccip_tx_chan_fifo #(
    parameter type T_ENTRY       = logic [7:0],
    parameter int  DEPTH         = 16,
    parameter int  ALMFULL_SLACK = 8
)(
    input  logic   pClk,
    input  logic   reset,
    input  logic   pushValid,
    input  T_ENTRY pushData,
    input  logic   popReq,
    output T_ENTRY popData,
    output logic   empty,
    output logic   almFull,
    output logic   ovfDrop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALMFULL_LEVEL = CNT_W'(DEPTH - ALMFULL_SLACK);

    T_ENTRY           mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             full;
    logic             pushAccept;
    logic             popAccept;

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign pushAccept = pushValid && !full;
    assign popAccept  = popReq && !empty;
    assign ovfDrop    = pushValid && full;
    assign popData    = mem[rdPtr];

    // Occupancy after this cycle; a simultaneous push and pop cancel out.
    always_comb begin
        countNext = count;
        case ({pushAccept, popAccept})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two. almFull looks
    // at the next occupancy so the AFU sees the level one edge earlier, and it
    // idles high in reset so nothing is issued before the buffer is ready.
    always_ff @(posedge pClk or posedge reset) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            almFull <= 1'b1;
        end else begin
            if (pushAccept) wrPtr <= wrPtr + 1'b1;
            if (popAccept)  rdPtr <= rdPtr + 1'b1;
            count   <= countNext;
            almFull <= (countNext >= ALMFULL_LEVEL);
        end
    end

    // Storage carries no reset; stale contents are never read because the
    // occupancy count gates every pop.
    always_ff @(posedge pClk) begin
        if (pushAccept) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/ccip_tx_throttle_buf.sv
// ---------------------------------------------------------------------------
// ccip_tx_throttle_buf
// Tx request buffer between the AFU request generators and the CCI-P
// interface register stage. c0 reads and c1 writes are queued per channel so
// requests issued after the FIU raises almost-full are absorbed; the queues
// drain in order whenever the FIU accepts. c2 MMIO responses pass through a
// single register.
//
// Ports:
//   pClk                 CCI-P interface clock
//   pck_cp2af_softReset  asynchronous active-high reset
//   af_sTx               AFU requests (c0, c1, c2)
//   fiu_c0TxAlmFull      FIU c0 almost-full (from the registered Rx struct)
//   fiu_c1TxAlmFull      FIU c1 almost-full (from the registered Rx struct)
//   af_c0TxAlmFull       slack-adjusted almost-full returned to the AFU, c0
//   af_c1TxAlmFull       slack-adjusted almost-full returned to the AFU, c1
//   buf_sTx              registered requests to the interface register stage
//   ovf_err              sticky overflow flags, bit0 = c0, bit1 = c1
// ---------------------------------------------------------------------------
module ccip_tx_throttle_buf
    import ccip_if_pkg::*;
    import ccip_tx_buf_pkg::*;
#(
    parameter int DEPTH         = TXBUF_DEPTH,
    parameter int ALMFULL_SLACK = TXBUF_ALMFULL_SLACK
)(
    input  logic        pClk,
    input  logic        pck_cp2af_softReset,
    input  t_if_ccip_Tx af_sTx,
    input  logic        fiu_c0TxAlmFull,
    input  logic        fiu_c1TxAlmFull,
    output logic        af_c0TxAlmFull,
    output logic        af_c1TxAlmFull,
    output t_if_ccip_Tx buf_sTx,
    output logic [1:0]  ovf_err
);

    t_c0_entry           c0Head;
    t_c1_entry           c1Head;
    t_c1_entry           c1PushData;
    logic                c0Empty;
    logic                c1Empty;
    logic                c0Pop;
    logic                c1Pop;
    logic                c0Drop;
    logic                c1Drop;
    logic [1:0]          beatsLeft;

    logic                c0OutValid;
    logic                c1OutValid;
    logic                c2OutValid;
    t_c0_entry           c0OutHdr;
    t_c1_entry           c1OutEntry;
    t_ccip_c2_RspMmioHdr c2OutHdr;
    t_ccip_mmioData      c2OutData;

    assign c1PushData = '{hdr: af_sTx.c1.hdr, data: af_sTx.c1.data};

    ccip_tx_chan_fifo #(
        .T_ENTRY       (t_c0_entry),
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) c0Fifo (
        .pClk      (pClk),
        .reset     (pck_cp2af_softReset),
        .pushValid (af_sTx.c0.valid),
        .pushData  (af_sTx.c0.hdr),
        .popReq    (c0Pop),
        .popData   (c0Head),
        .empty     (c0Empty),
        .almFull   (af_c0TxAlmFull),
        .ovfDrop   (c0Drop)
    );

    ccip_tx_chan_fifo #(
        .T_ENTRY       (t_c1_entry),
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (ALMFULL_SLACK)
    ) c1Fifo (
        .pClk      (pClk),
        .reset     (pck_cp2af_softReset),
        .pushValid (af_sTx.c1.valid),
        .pushData  (c1PushData),
        .popReq    (c1Pop),
        .popData   (c1Head),
        .empty     (c1Empty),
        .almFull   (af_c1TxAlmFull),
        .ovfDrop   (c1Drop)
    );

    // A multi-line write must reach the FIU unbroken, so once its first beat
    // has left, the remaining beats ignore FIU almost-full. An empty FIFO in
    // the middle of a burst simply stalls until the AFU supplies the beat.
    assign c0Pop = !c0Empty && !fiu_c0TxAlmFull;
    assign c1Pop = !c1Empty && ((beatsLeft != 2'd0) || !fiu_c1TxAlmFull);

    // Valid bits, the burst tracker and the sticky overflow flags are the only
    // state that must be cleared; reset abandons any burst in progress.
    always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            c0OutValid <= 1'b0;
            c1OutValid <= 1'b0;
            c2OutValid <= 1'b0;
            beatsLeft  <= 2'd0;
            ovf_err    <= 2'b00;
        end else begin
            c0OutValid <= c0Pop;
            c1OutValid <= c1Pop;
            c2OutValid <= af_sTx.c2.mmioRdValid;
            ovf_err    <= ovf_err | {c1Drop, c0Drop};
            if (c1Pop) begin
                if (beatsLeft != 2'd0) beatsLeft <= beatsLeft - 1'b1;
                else                   beatsLeft <= extraBeats(c1Head.hdr);
            end
        end
    end

    // Payload registers only load on a pop; downstream qualifies them with
    // the valid bits above, so they need no reset.
    always_ff @(posedge pClk) begin
        if (c0Pop) c0OutHdr   <= c0Head;
        if (c1Pop) c1OutEntry <= c1Head;
        c2OutHdr  <= af_sTx.c2.hdr;
        c2OutData <= af_sTx.c2.data;
    end

    // Reassemble the registered fields into the outgoing Tx struct.
    always_comb begin
        buf_sTx                = '0;
        buf_sTx.c0.hdr         = c0OutHdr;
        buf_sTx.c0.valid       = c0OutValid;
        buf_sTx.c1.hdr         = c1OutEntry.hdr;
        buf_sTx.c1.data        = c1OutEntry.data;
        buf_sTx.c1.valid       = c1OutValid;
        buf_sTx.c2.hdr         = c2OutHdr;
        buf_sTx.c2.data        = c2OutData;
        buf_sTx.c2.mmioRdValid = c2OutValid;
    end

endmodule

// File: doc/ccip_tx_throttle_buf.md
Name: ccip_tx_throttle_buf

Overview:
- Per-channel Tx request buffer between the AFU request generators and the CCI-P interface register stage.
- Absorbs c0 (read) and c1 (write) requests the AFU issues after the FIU asserts almost-full.
- Re-times FIU almost-full into a slack-adjusted almost-full back to the AFU.
- Drains in order whenever the FIU accepts; c2 (MMIO response) passes through with one register of latency.

Parameters:
- DEPTH, 16, entries per channel FIFO; power of two, minimum 8.
- ALMFULL_SLACK, 8, free entries reserved after AFU almost-full asserts; covers CCI-P's post-almost-full issue allowance.

Ports:
- pClk  in  1  CCI-P interface clock.
- pck_cp2af_softReset  in  1  asynchronous, active-high reset.
- af_sTx  in  t_if_ccip_Tx  AFU requests (c0, c1, c2).
- fiu_c0TxAlmFull  in  1  FIU c0 almost-full, taken from the registered Rx struct.
- fiu_c1TxAlmFull  in  1  FIU c1 almost-full, taken from the registered Rx struct.
- af_c0TxAlmFull  out  1  almost-full to the AFU, c0.
- af_c1TxAlmFull  out  1  almost-full to the AFU, c1.
- buf_sTx  out  t_if_ccip_Tx  to the interface register stage.
- ovf_err  out  2  sticky overflow flags; bit0 = c0, bit1 = c1.

Behaviour:
- Reset (async assert; release synchronised by the clock):
  - Pointers and counts go to 0.
  - All buf_sTx valids = 0; hdr/data fields are don't-care, but bench compares them only when valid.
  - ovf_err = 0.
  - af_c0TxAlmFull = af_c1TxAlmFull = 1 while reset is asserted. Both go to 0 at the first pClk edge after release.
- Reset mid-operation discards all buffered entries. No partial packet is emitted afterwards.
- Push, per channel: af_sTx.cN.valid = 1 and count < DEPTH stores {hdr[, data]}.
- Push when count == DEPTH: entry is dropped and ovf_err[N] sets. Only reset clears it. There is no same-cycle bypass of a full FIFO.
- AFU almost-full: af_cNTxAlmFull is registered, = (count_next >= DEPTH - ALMFULL_SLACK).
- Pop eligibility, per channel:
  - count > 0 and fiu_cNTxAlmFull == 0, or
  - c1 is in the middle of a multi-line packet (see below).
- Pop output is registered: buf_sTx.cN.valid = 1 with the popped hdr/data on the cycle after pop.
- Latency: minimum 2 cycles from AFU valid to buf_sTx valid (write cycle, then pop/output register).
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Ordering: strict FIFO per channel. No ordering is enforced between c0 and c1.
- c1 multi-line packets:
  - Popping a beat with hdr.sop = 1 and hdr.cl_len != eCL_LEN_1 loads beats_left = cl_len (1 or 3).
  - While beats_left > 0, pop ignores fiu_c1TxAlmFull. Pop stalls only if empty, which is an AFU violation; the block waits and emits nothing.
  - beats_left decrements per popped beat.
  - A new sop honours almost-full again.
- c2: buf_sTx.c2 <= af_sTx.c2 every cycle (1-cycle register, never throttled).
- Count width is $clog2(DEPTH+1); pointer width is $clog2(DEPTH).

Decomposition:
- Shared package (ccip_tx_buf_pkg):
  - typedefs t_c0_entry (t_ccip_c0_ReqMemHdr) and t_c1_entry ({t_ccip_c1_ReqMemHdr, t_ccip_clData}).
  - DEPTH/ALMFULL_SLACK defaults.
  - Uses ccip_if_pkg types.
- Sub-module ccip_tx_chan_fifo:
  - Parameterized by entry type and DEPTH.
  - Provides push/pop/count/full/empty/almfull logic.
  - Instantiated once per channel.
- The multi-line beats_left tracker lives in the top level, c1 only.

Test Plan:
- Reset release, idle: both af_cNTxAlmFull fall to 0 one edge after release; all buf_sTx valids 0; ovf_err = 0.
- 5 c0 reads on consecutive cycles, FIU almfull = 0: 5 buf_sTx.c0 valids, each 2 cycles after its push, same order, addresses intact.
- FIU c1 almfull held 1, AFU pushes 8 single-line writes: af_c1TxAlmFull rises after the 8th push (count 8 ≥ 16-8). No output while FIU almfull = 1. Deassert FIU almfull: 8 writes drain back-to-back in order.
- 4-line write (sop = 1, cl_len = eCL_LEN_4), FIU c1 almfull rises after beat 1 is popped: beats 2–4 still emitted on consecutive cycles. A following sop write waits for almfull = 0.
- Push 17 c0 requests with FIU almfull = 1 and AFU ignoring af almfull: 16 buffered, 17th dropped, ovf_err = 2'b01. Drain yields exactly 16.
- Assert reset with 6 c1 entries buffered: valids drop immediately; after release, zero c1 outputs; c2 passthrough resumes with 1-cycle latency.
